// File: rtl/generic_skid_slice.sv
// Two-entry valid/ready register slice for packed struct payloads.
// Every output decodes from registered state, so i_valid and i_ready have no combinational path to o_ready or o_valid.
module generic_skid_slice #(
    parameter int WIDTH       = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic [COUNT_WIDTH-1:0] o_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [WIDTH-1:0]       main_reg;
    logic [WIDTH-1:0]       main_next;
    logic [WIDTH-1:0]       skid_reg;
    logic [WIDTH-1:0]       skid_next;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   in_fire;
    logic                   out_fire;

    assign o_ready = (state_reg != ST_TWO);
    assign o_valid = (state_reg != ST_EMPTY);
    assign o_full  = (state_reg == ST_TWO);
    // The output always comes from main. Skid data reaches o_data only by being moved into main.
    assign o_data  = main_reg;
    assign o_count = count_reg;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        count_next = count_reg;
        if (out_fire) begin
            count_next = count_reg + 1'b1;
        end
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_next = ST_ONE;
                    main_next  = i_data;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_next = ST_TWO;
                    skid_next  = i_data;
                end else if (!in_fire && out_fire) begin
                    state_next = ST_EMPTY;
                end else if (in_fire && out_fire) begin
                    main_next = i_data;
                end
            end
            ST_TWO: begin
                // in_fire cannot occur here because o_ready is low.
                if (out_fire) begin
                    state_next = ST_ONE;
                    main_next  = skid_reg;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: doc/generic_skid_slice.md
Name: generic_skid_slice

Overview:
- Two-entry valid/ready register slice for the packed struct payloads carried by the generic interfaces (e.g. the 2-bit {a, b} struct package type).
- Sits directly downstream of the interface producer. It registers the payload, breaks the combinational ready path, and hands the payload to the consuming stage with full throughput.
- Counts completed output transfers for debug and observability.

Parameters:
- WIDTH, 2, payload width in bits; matches the packed struct width. Minimum 1.
- COUNT_WIDTH, 8, width of the output-transfer counter. Minimum 1.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_valid  input  1  upstream payload valid
- o_ready  output  1  slice can accept a payload this cycle
- i_data  input  WIDTH  upstream payload (packed struct bits, MSB = first field)
- o_valid  output  1  downstream payload valid
- i_ready  input  1  downstream accepts payload
- o_data  output  WIDTH  downstream payload
- o_full  output  1  both entries occupied
- o_count  output  COUNT_WIDTH  number of output transfers, modulo 2^COUNT_WIDTH

Behaviour:
- Transfer rules:
  - Input fire (in_fire) = i_valid & o_ready.
  - Output fire (out_fire) = o_valid & i_ready.
- State machine (registered): EMPTY, ONE, TWO.
- Storage: main register (drives o_data) and skid register.
- Output decodes, combinational from registered state only. No path from i_valid or i_ready to o_ready or o_valid.
  - o_ready = (state != TWO)
  - o_valid = (state != EMPTY)
  - o_full = (state == TWO)
- Transitions:
  - EMPTY:
    - in_fire -> ONE, main <= i_data.
    - Otherwise stays EMPTY.
  - ONE:
    - in_fire & !out_fire -> TWO, skid <= i_data.
    - !in_fire & out_fire -> EMPTY.
    - in_fire & out_fire -> ONE, main <= i_data.
    - Neither -> ONE, hold.
  - TWO:
    - out_fire -> ONE, main <= skid.
    - Otherwise hold.
    - in_fire is impossible because o_ready = 0.
- Latency: a payload accepted in cycle N appears on o_data with o_valid in cycle N+1 when the slice was EMPTY.
- Throughput: one transfer per cycle is sustained when i_ready stays high.
- Ordering: strict FIFO; no payload is dropped or duplicated.
- Stability: while o_valid & !i_ready, o_data and o_valid hold unchanged.
- Counter: o_count increments by 1 on each out_fire and wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Reset (i_rst_n low, asynchronous, effective immediately):
  - state = EMPTY, main = 0, skid = 0, o_count = 0.
  - Hence o_valid = 0, o_ready = 1, o_full = 0, o_data = 0.
- Reset asserted mid-operation discards all buffered payloads and clears the count. The first cycle after deassertion behaves as EMPTY.
- Combinational input ignore rules:
  - i_data is ignored when in_fire = 0.
  - i_ready is ignored when o_valid = 0.
  - Neither input may alter state in those cases.
- X-safety: o_data is never taken from the skid register unless the FSM is in TWO.

Test Plan:
- Reset then idle: hold i_rst_n low for 3 cycles, release; i_valid = 0 -> o_valid = 0, o_ready = 1, o_count = 0, o_data = 0 for 5 cycles.
- Single transfer, WIDTH = 2: cycle 0 i_valid = 1, i_data = 2'b10, i_ready = 1 -> cycle 1 o_valid = 1, o_data = 2'b10; cycle 2 o_valid = 0, o_count = 1.
- Backpressure fill:
  - Stimulus: i_ready = 0; offer 2'b01, then 2'b11, then 2'b00.
  - After 2 accepts: o_full = 1, o_ready = 0, 2'b00 is held off, o_data = 2'b01.
  - Then raise i_ready: outputs 01, 11, 00 in consecutive cycles; o_count = 3.
- Full throughput: stream 0,1,2,3 repeated for 260 cycles with i_valid = i_ready = 1 -> output matches input delayed 1 cycle; o_count wraps to 260 mod 256 = 4.
- Simultaneous fire in ONE: slice holds 2'b01, i_valid = 1 with 2'b10, i_ready = 1 in the same cycle -> next cycle state ONE, o_data = 2'b10, o_full = 0.
- Mid-operation reset: with state TWO and o_count = 5, pulse i_rst_n low asynchronously between clock edges -> o_valid, o_full and o_count drop to 0 immediately and o_ready = 1; old payloads never appear afterwards.
